// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one W-bit bitwise logic unit among N requesters.
// Each accepted request runs IDLE -> EXEC -> DONE, so one operation completes every 3 cycles.
module logic_op_arbiter #(
   parameter int unsigned W = 8,
   parameter int unsigned N = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N-1:0]           req,
   input  logic [3*N-1:0]         op,
   input  logic [W*N-1:0]         a,
   input  logic [W*N-1:0]         b,
   output logic [N-1:0]           gnt,
   output logic [N-1:0]           done,
   output logic [W-1:0]           result,
   output logic [$clog2(N)-1:0]   result_id,
   output logic                   err,
   output logic                   busy
);

   localparam int unsigned IDW = $clog2(N);
   localparam int unsigned SW  = IDW + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [IDW-1:0]   ptr_q, ptr_d;
   logic [IDW-1:0]   id_q, id_d;
   logic [2:0]       op_q, op_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic [N-1:0]     gnt_q, gnt_d;
   logic [N-1:0]     done_q, done_d;
   logic             err_q, err_d;
   logic [W-1:0]     result_q, result_d;
   logic [IDW-1:0]   result_id_q, result_id_d;
   logic             busy_q, busy_d;

   logic [IDW-1:0]   win;
   logic             win_vld;
   logic [SW-1:0]    scan;
   logic [2:0]       op_sel;
   logic [W-1:0]     a_sel;
   logic [W-1:0]     b_sel;
   logic [W-1:0]     alu_res;
   logic             alu_err;

   // Round-robin scan starting at ptr, wrapping modulo N.
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      scan    = '0;
      for (int unsigned k = 0; k < N; k++) begin
         scan = SW'(ptr_q) + SW'(k);
         if (scan >= SW'(N)) scan = scan - SW'(N);
         if (!win_vld && req[scan[IDW-1:0]]) begin
            win_vld = 1'b1;
            win     = scan[IDW-1:0];
         end
      end
   end

   // Operand mux for the winning requester.
   always_comb begin
      op_sel = '0;
      a_sel  = '0;
      b_sel  = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (win == IDW'(i)) begin
            op_sel = op[3*i +: 3];
            a_sel  = a[W*i +: W];
            b_sel  = b[W*i +: W];
         end
      end
   end

   // Shared logic unit operating on the latched operands.
   always_comb begin
      alu_res = '0;
      alu_err = 1'b0;
      case (op_q)
         3'd0: alu_res = a_q & b_q;
         3'd1: alu_res = a_q | b_q;
         3'd2: alu_res = ~a_q;
         3'd3: alu_res = ~(a_q & b_q);
         3'd4: alu_res = ~(a_q | b_q);
         3'd5: alu_res = a_q ^ b_q;
         3'd6: alu_res = a_q ~^ b_q;
         3'd7: alu_err = 1'b1;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      id_d        = id_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      gnt_d       = '0;
      done_d      = '0;
      err_d       = 1'b0;
      result_d    = result_q;
      result_id_d = result_id_q;
      case (state_q)
         ST_IDLE: begin
            if (win_vld) begin
               state_d = ST_EXEC;
               id_d    = win;
               op_d    = op_sel;
               a_d     = a_sel;
               b_d     = b_sel;
               gnt_d   = N'(1) << win;
            end
         end
         ST_EXEC: begin
            state_d     = ST_DONE;
            result_d    = alu_res;
            err_d       = alu_err;
            result_id_d = id_q;
            done_d      = N'(1) << id_q;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            ptr_d   = (id_q == IDW'(N - 1)) ? '0 : id_q + IDW'(1);
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         id_q        <= '0;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         gnt_q       <= '0;
         done_q      <= '0;
         err_q       <= 1'b0;
         result_q    <= '0;
         result_id_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         id_q        <= id_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         gnt_q       <= gnt_d;
         done_q      <= done_d;
         err_q       <= err_d;
         result_q    <= result_d;
         result_id_q <= result_id_d;
         busy_q      <= busy_d;
      end
   end

   assign gnt       = gnt_q;
   assign done      = done_q;
   assign err       = err_q;
   assign result    = result_q;
   assign result_id = result_id_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Self-checking bench for logic_op_arbiter: directed scenarios plus randomized
// traffic checked against a round-robin / bitwise-op reference model.
module tb_logic_op_arbiter;

   localparam int unsigned W   = 8;
   localparam int unsigned N   = 4;
   localparam int unsigned IDW = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [N-1:0]     req = '0;
   logic [3*N-1:0]   op = '0;
   logic [W*N-1:0]   a = '0;
   logic [W*N-1:0]   b = '0;
   logic [N-1:0]     gnt;
   logic [N-1:0]     done;
   logic [W-1:0]     result;
   logic [IDW-1:0]   result_id;
   logic             err;
   logic             busy;

   int n_cmp = 0;
   int n_err = 0;
   int m_ptr = 0;

   logic_op_arbiter #(.W(W), .N(N)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .op(op), .a(a), .b(b),
      .gnt(gnt), .done(done), .result(result), .result_id(result_id),
      .err(err), .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference model: opcode semantics and round-robin winner.
   function automatic logic [W-1:0] ref_res(int o, logic [W-1:0] x, logic [W-1:0] y);
      case (o)
         0: return x & y;
         1: return x | y;
         2: return ~x;
         3: return ~(x & y);
         4: return ~(x | y);
         5: return x ^ y;
         6: return ~(x ^ y);
         default: return '0;
      endcase
   endfunction

   function automatic int ref_winner(logic [N-1:0] r, int p);
      for (int k = 0; k < N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   function automatic int onehot_idx(logic [N-1:0] v);
      if ($countones(v) != 1) return -1;
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic set_slot(int i, int o, logic [W-1:0] x, logic [W-1:0] y);
      op[3*i +: 3] = 3'(o);
      a[W*i +: W]  = x;
      b[W*i +: W]  = y;
   endtask

   // Observes one operation from the current negedge; no checking here.
   task automatic run_op(input bit drop, input bit mod_en, input logic [W-1:0] mod_a,
                         output int g_idx, output int g_cyc, output int g_cnt,
                         output int d_idx, output int d_cyc, output int d_cnt,
                         output logic [W-1:0] res, output logic [IDW-1:0] rid,
                         output logic e, output bit ovl, output bit tmo, output logic bsy_end);
      g_idx = -1; g_cyc = 0; g_cnt = 0; d_idx = -1; d_cyc = 0; d_cnt = 0;
      res = '0; rid = '0; e = 1'b0; ovl = 1'b0; bsy_end = 1'b1;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         @(negedge clk);
         if (gnt != '0 && done != '0) ovl = 1'b1;
         if (gnt != '0) begin
            g_cnt++;
            g_idx = onehot_idx(gnt);
            g_cyc = cyc;
            if (g_idx >= 0) begin
               if (drop) req[g_idx] = 1'b0;
               if (mod_en) a[W*g_idx +: W] = mod_a;
            end
         end
         if (done != '0) begin
            d_cnt++;
            d_idx = onehot_idx(done);
            d_cyc = cyc;
            res = result; rid = result_id; e = err;
         end
         if (d_cnt > 0 && cyc > d_cyc) begin
            bsy_end = busy;
            break;
         end
      end
      tmo = (d_cnt == 0);
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_cmp++;
      if ({gnt, done, err, busy} !== '0) begin
         n_err++; $display("FAIL reset_ctrl got gnt=%b done=%b err=%b busy=%b want all 0", gnt, done, err, busy);
      end
      n_cmp++;
      if ({result, result_id} !== '0) begin
         n_err++; $display("FAIL reset_data got result=%h id=%0d want 0/0", result, result_id);
      end
      rst_n = 1'b1;
      m_ptr = 0;
      @(negedge clk);
   endtask

   task automatic test_single();
      int gi, gc, gn, di, dc, dn; logic [W-1:0] r; logic [IDW-1:0] id; logic e, be; bit ov, to;
      set_slot(0, 5, 8'hF0, 8'h3C);
      req = 4'b0001;
      run_op(1, 0, '0, gi, gc, gn, di, dc, dn, r, id, e, ov, to, be);
      n_cmp++;
      if (to || gi !== 0 || gc !== 1 || gn !== 1) begin
         n_err++; $display("FAIL single_gnt got idx=%0d cyc=%0d cnt=%0d tmo=%0d want 0/1/1/0", gi, gc, gn, to);
      end
      n_cmp++;
      if (di !== 0 || dc !== 2 || dn !== 1 || ov) begin
         n_err++; $display("FAIL single_done got idx=%0d cyc=%0d cnt=%0d ovl=%0d want 0/2/1/0", di, dc, dn, ov);
      end
      n_cmp++;
      if (r !== 8'hCC || id !== 2'd0 || e !== 1'b0 || be !== 1'b0) begin
         n_err++; $display("FAIL single_result got res=%h id=%0d err=%b busy=%b want cc/0/0/0", r, id, e, be);
      end
      n_cmp++;
      if (result !== 8'hCC) begin
         n_err++; $display("FAIL single_hold got %h want cc", result);
      end
      m_ptr = 1;
   endtask

   task automatic test_opcode_sweep();
      int gi, gc, gn, di, dc, dn; logic [W-1:0] r; logic [IDW-1:0] id; logic e, be; bit ov, to;
      logic [W-1:0] want [8] = '{8'h05, 8'hAF, 8'h5A, 8'hFA, 8'h50, 8'hAA, 8'h55, 8'h00};
      for (int o = 0; o < 8; o++) begin
         set_slot(2, o, 8'hA5, 8'h0F);
         req = 4'b0100;
         run_op(1, 0, '0, gi, gc, gn, di, dc, dn, r, id, e, ov, to, be);
         n_cmp++;
         if (to || gi !== 2 || di !== 2 || r !== want[o] || id !== 2'd2 || e !== (o == 7)) begin
            n_err++; $display("FAIL sweep_op%0d got g=%0d d=%0d res=%h id=%0d err=%b want 2/2/%h/2/%0d",
                              o, gi, di, r, id, e, want[o], (o == 7));
         end
      end
      m_ptr = 3;
   endtask

   task automatic test_fairness();
      int gi, gc, gn, di, dc, dn, exp; logic [W-1:0] r; logic [IDW-1:0] id; logic e, be; bit ov, to;
      for (int i = 0; i < N; i++) set_slot(i, 1, 8'(i), 8'h10);
      // Serve requester 3 first so the 12-op run starts from ptr=0.
      req = 4'b1000;
      run_op(1, 0, '0, gi, gc, gn, di, dc, dn, r, id, e, ov, to, be);
      m_ptr = 0;
      req = 4'b1111;
      for (int k = 0; k < 12; k++) begin
         exp = ref_winner(req, m_ptr);
         run_op(0, 0, '0, gi, gc, gn, di, dc, dn, r, id, e, ov, to, be);
         if (k == 11) req = '0;
         n_cmp++;
         if (to || gi !== exp || di !== exp || ov || gc !== 1 || r !== (8'(exp) | 8'h10)) begin
            n_err++; $display("FAIL fair_op%0d got g=%0d d=%0d gcyc=%0d ovl=%0d res=%h want %0d/%0d/1/0/%h",
                              k, gi, di, gc, ov, r, exp, exp, 8'(exp) | 8'h10);
         end
         m_ptr = (exp + 1) % N;
      end
   endtask

   task automatic test_pointer_wrap();
      int gi, gc, gn, di, dc, dn; logic [W-1:0] r; logic [IDW-1:0] id; logic e, be; bit ov, to;
      req = 4'b1001;
      run_op(1, 0, '0, gi, gc, gn, di, dc, dn, r, id, e, ov, to, be);
      n_cmp++;
      if (to || gi !== 0 || di !== 0) begin
         n_err++; $display("FAIL wrap_first got g=%0d d=%0d want 0/0", gi, di);
      end
      req = 4'b1001;
      run_op(1, 0, '0, gi, gc, gn, di, dc, dn, r, id, e, ov, to, be);
      n_cmp++;
      if (to || gi !== 3 || di !== 3 || id !== 2'd3) begin
         n_err++; $display("FAIL wrap_second got g=%0d d=%0d id=%0d want 3/3/3", gi, di, id);
      end
      req = '0;
      m_ptr = 0;
   endtask

   task automatic test_operand_change();
      int gi, gc, gn, di, dc, dn; logic [W-1:0] r; logic [IDW-1:0] id; logic e, be; bit ov, to;
      set_slot(0, 0, 8'hFF, 8'hFF);
      req = 4'b0001;
      run_op(1, 1, 8'h00, gi, gc, gn, di, dc, dn, r, id, e, ov, to, be);
      n_cmp++;
      if (to || di !== 0 || r !== 8'hFF) begin
         n_err++; $display("FAIL operand_latch got d=%0d res=%h want 0/ff", di, r);
      end
      m_ptr = 1;
   endtask

   task automatic test_reset_mid_op();
      int gi, gc, gn, di, dc, dn; logic [W-1:0] r; logic [IDW-1:0] id; logic e, be; bit ov, to;
      bit seen_gnt, seen_done;
      set_slot(1, 1, 8'h11, 8'h22);
      req = 4'b0010;
      run_op(1, 0, '0, gi, gc, gn, di, dc, dn, r, id, e, ov, to, be);
      set_slot(2, 6, 8'h3C, 8'hC3);
      req = 4'b0100;
      seen_gnt = 1'b0;
      for (int c = 0; c < 6 && !seen_gnt; c++) begin
         @(negedge clk);
         if (gnt != '0) seen_gnt = 1'b1;
      end
      n_cmp++;
      if (!seen_gnt) begin
         n_err++; $display("FAIL rst_mid_gnt got no grant want gnt=0100");
      end
      rst_n = 1'b0;
      req = '0;
      #1;
      n_cmp++;
      if ({gnt, done, err, busy, result, result_id} !== '0) begin
         n_err++; $display("FAIL rst_mid_clear got gnt=%b done=%b err=%b busy=%b res=%h id=%0d want 0",
                           gnt, done, err, busy, result, result_id);
      end
      seen_done = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (done != '0 || busy) seen_done = 1'b1;
      end
      rst_n = 1'b1;
      @(negedge clk);
      if (done != '0) seen_done = 1'b1;
      n_cmp++;
      if (seen_done) begin
         n_err++; $display("FAIL rst_mid_nodone got done/busy activity want none");
      end
      m_ptr = 0;
      set_slot(0, 4, 8'h0F, 8'h30);
      req = 4'b0101;
      run_op(1, 0, '0, gi, gc, gn, di, dc, dn, r, id, e, ov, to, be);
      n_cmp++;
      if (to || gi !== 0 || r !== 8'hC0) begin
         n_err++; $display("FAIL rst_mid_ptr got g=%0d res=%h want 0/c0", gi, r);
      end
      // Requester 2 is still pending; after the reset case, grant it alone.
      rst_n = 1'b0; req = '0;
      @(negedge clk);
      rst_n = 1'b1;
      req = 4'b0100;
      run_op(1, 0, '0, gi, gc, gn, di, dc, dn, r, id, e, ov, to, be);
      n_cmp++;
      if (to || gi !== 2 || di !== 2 || r !== 8'h00) begin
         n_err++; $display("FAIL rst_mid_req2 got g=%0d d=%0d res=%h want 2/2/00", gi, di, r);
      end
      m_ptr = 3;
   endtask

   task automatic test_random();
      int gi, gc, gn, di, dc, dn, exp; logic [W-1:0] r, exp_r; logic [IDW-1:0] id; logic e, be; bit ov, to;
      int ops [N]; logic [W-1:0] xs [N]; logic [W-1:0] ys [N];
      for (int k = 0; k < 40; k++) begin
         for (int i = 0; i < N; i++) begin
            ops[i] = $urandom_range(0, 7);
            xs[i] = 8'($urandom);
            ys[i] = 8'($urandom);
            set_slot(i, ops[i], xs[i], ys[i]);
         end
         req = 4'($urandom_range(1, 15));
         exp = ref_winner(req, m_ptr);
         exp_r = ref_res(ops[exp], xs[exp], ys[exp]);
         run_op(1, ($urandom_range(0, 1) == 1), 8'($urandom), gi, gc, gn, di, dc, dn, r, id, e, ov, to, be);
         n_cmp++;
         if (to || gi !== exp || di !== exp || id !== IDW'(exp) || r !== exp_r ||
             e !== (ops[exp] == 7) || ov || gc !== 1 || dc !== 2) begin
            n_err++; $display("FAIL rand_op%0d got g=%0d d=%0d id=%0d res=%h err=%b want %0d/%0d/%0d/%h/%0d",
                              k, gi, di, id, r, e, exp, exp, exp, exp_r, (ops[exp] == 7));
         end
         m_ptr = (exp + 1) % N;
      end
      req = '0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_opcode_sweep();
      test_fairness();
      test_pointer_wrap();
      test_operand_change();
      test_reset_mid_op();
      test_random();
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
